// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths, timeout default and the FSM state
// encoding used by both the master bridge and the slave memory.
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH     = 10;
    localparam int unsigned APB_DATA_WIDTH     = 32;
    localparam int unsigned APB_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StSetup  = 2'b01,
        StAccess = 2'b10
    } apb_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: host valid/ready command in, APB SETUP/ACCESS out,
// one-cycle response pulse back. Define APB_TIMEOUT_EN to bound the ACCESS wait.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH
`ifdef APB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
`endif
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  pselx,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    apb_state_e state_q;
    logic       cmd_fire;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] timer_q;
    logic               timeout;

    // Fires in the last permitted ACCESS cycle that still has pready low.
    assign timeout = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
`endif

    // The only combinational output: a new command may land in IDLE or as the
    // current transfer completes.
    assign cmd_ready = presetn &&
                       ((state_q == StIdle) || ((state_q == StAccess) && pready));
    assign cmd_fire  = cmd_valid && cmd_ready;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q   <= StIdle;
            pselx     <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            timer_q   <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;

            // Address/data/direction only change on acceptance, so they hold
            // through ACCESS and keep their last value while idle.
            if (cmd_fire) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
            end

            unique case (state_q)
                StIdle: begin
                    if (cmd_fire) begin
                        state_q <= StSetup;
                        pselx   <= 1'b1;
                        penable <= 1'b0;
                    end
                end
                StSetup: begin
                    state_q <= StAccess;
                    penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    timer_q <= '0;
`endif
                end
                StAccess: begin
                    if (pready) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        rsp_err   <= pslverr;
                        penable   <= 1'b0;
                        if (cmd_valid) begin
                            state_q <= StSetup;
                        end else begin
                            state_q <= StIdle;
                            pselx   <= 1'b0;
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else if (timeout) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        pselx     <= 1'b0;
                        penable   <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= StIdle;
                    pselx   <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule
